// File: rtl/warp_dispatch.sv
// Issue-side controller: accepts one instruction per handshake and broadcasts it
// to the enabled lanes, then waits for all of them to report ready or times out.
module warp_dispatch #(
    parameter int unsigned NUM_LANES = 8,
    parameter int unsigned INST_W    = 32,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_inst_valid,
    input  logic [INST_W-1:0]    i_inst_data,
    input  logic [NUM_LANES-1:0] i_inst_mask,
    output logic                 o_inst_ready,
    output logic [NUM_LANES-1:0] o_lane_enable,
    output logic                 o_execute,
    output logic [INST_W-1:0]    o_instruction,
    input  logic [NUM_LANES-1:0] i_lane_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout_err,
    output logic [NUM_LANES-1:0] o_timeout_lanes,
    output logic [15:0]          o_issue_count
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_WAIT
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [INST_W-1:0]    r_inst_q;
    logic [NUM_LANES-1:0] r_mask_q;
    logic [15:0]          r_issue_count;
    logic [NUM_LANES-1:0] r_timeout_lanes;
    logic                 r_done;
    logic                 r_timeout_err;
    logic [CW-1:0]        r_wait_cnt;

    logic w_accept;
    logic w_complete;
    logic w_expired;
    logic w_done_set;
    logic w_to_set;

    // Never issue to a lane that is still busy with earlier work.
    assign o_inst_ready = (r_state == S_IDLE) &&
                          ((i_lane_ready & i_inst_mask) == i_inst_mask);
    assign w_accept     = i_inst_valid && o_inst_ready;
    assign w_complete   = (i_lane_ready & r_mask_q) == r_mask_q;
    assign w_expired    = (r_wait_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_next     = r_state;
        w_done_set = 1'b0;
        w_to_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    // An empty mask completes immediately without strobing execute.
                    if (i_inst_mask == '0) begin
                        w_done_set = 1'b1;
                    end else begin
                        w_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE:  w_next = S_SETTLE;
            S_SETTLE: w_next = S_WAIT;
            S_WAIT: begin
                if (w_complete) begin
                    w_next     = S_IDLE;
                    w_done_set = 1'b1;
                end else if (w_expired) begin
                    w_next   = S_IDLE;
                    w_to_set = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= S_IDLE;
            r_inst_q        <= '0;
            r_mask_q        <= '0;
            r_issue_count   <= '0;
            r_timeout_lanes <= '0;
            r_done          <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_wait_cnt      <= '0;
        end else begin
            r_state       <= w_next;
            r_done        <= w_done_set;
            r_timeout_err <= w_to_set;
            if (w_accept) begin
                r_inst_q        <= i_inst_data;
                r_mask_q        <= i_inst_mask;
                r_issue_count   <= r_issue_count + 16'd1;
                r_timeout_lanes <= '0;
            end
            if (w_to_set) begin
                r_timeout_lanes <= r_mask_q & ~i_lane_ready;
            end
            if (r_state == S_SETTLE) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end
        end
    end

    assign o_execute       = (r_state == S_ISSUE);
    assign o_busy          = (r_state != S_IDLE);
    assign o_lane_enable   = (r_state != S_IDLE) ? r_mask_q : '0;
    assign o_instruction   = r_inst_q;
    assign o_done          = r_done;
    assign o_timeout_err   = r_timeout_err;
    assign o_timeout_lanes = r_timeout_lanes;
    assign o_issue_count   = r_issue_count;

endmodule
